aes_sbox_sched: RTL

Round-robin scheduler that shares one pipelined, DOM-masked AES S-box (input/output linear maps plus GF inversion, fixed latency) between two requesters: the state datapath (SubBytes, requester 0) and the key schedule (SubWord, requester 1). It issues one masked byte per cycle into the free-running S-box pipeline and gates each issue on fresh randomness. It tracks every in-flight byte with a tag and routes each S-box result back to the requester that issued it, in issue order.

---
 rtl/aes_dom_pkg.sv | 18 +
 rtl/aes_sbox_sched_tag_pipe.sv | 44 ++++
 rtl/aes_sbox_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_dom_pkg.sv
// Shared types and default sizes for the DOM-masked AES S-box scheduler.
package aes_dom_pkg;

  localparam int SHARES_DEF   = 2;
  localparam int PIPE_LAT_DEF = 4;
  localparam int RAND_W_DEF   = 18;

  typedef enum logic {
    REQ_STATE = 1'b0,
    REQ_KEY   = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/aes_sbox_sched_tag_pipe.sv
// Tag shift register that travels alongside the S-box pipeline so every
// result can be routed back to the requester that issued it.
module sbox_tag_pipe
  import aes_dom_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
) (
  input  logic ClkxCI,
  input  logic RstxRI,
  input  tag_t TagInxDI,
  output tag_t TagOutxDO,
  output logic AnyValidxSO
);

  tag_t [DEPTH-1:0] pipe_q, pipe_d;
  logic any_valid;

  // Shift every cycle; the S-box never stalls, so neither does the tag pipe
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = TagInxDI;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag storage; reset discards every in-flight byte
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  // Any in-flight entry keeps the scheduler busy
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | pipe_q[i].valid;
    end
  end

  assign TagOutxDO   = pipe_q[DEPTH-1];
  assign AnyValidxSO = any_valid;

endmodule

// File: rtl/aes_sbox_sched.sv
// Round-robin sharing of one pipelined masked S-box between the state
// datapath (requester 0) and the key schedule (requester 1).
module aes_sbox_sched
  import aes_dom_pkg::*;
#(
  parameter int SHARES   = SHARES_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int RAND_W   = RAND_W_DEF
) (
  input  logic                  ClkxCI,
  input  logic                  RstxRI,
  input  logic                  Req0ValidxSI,
  input  logic                  Req1ValidxSI,
  output logic                  Req0ReadyxSO,
  output logic                  Req1ReadyxSO,
  input  logic [8*SHARES-1:0]   Req0DataxDI,
  input  logic [8*SHARES-1:0]   Req1DataxDI,
  output logic                  Rsp0ValidxSO,
  output logic                  Rsp1ValidxSO,
  output logic [8*SHARES-1:0]   Rsp0DataxDO,
  output logic [8*SHARES-1:0]   Rsp1DataxDO,
  input  logic                  RandValidxSI,
  output logic                  RandReadyxSO,
  input  logic [RAND_W-1:0]     RandxDI,
  output logic                  SboxValidxSO,
  output logic [8*SHARES-1:0]   SboxInxDO,
  output logic [RAND_W-1:0]     SboxRandxDO,
  input  logic [8*SHARES-1:0]   SboxOutxDI,
  output logic                  BusyxSO
);

  localparam int DW = 8 * SHARES;

  logic              issue;
  req_id_e           grant_id;
  req_id_e           last_q, last_d;
  logic              sbox_valid_q, sbox_valid_d;
  req_id_e           sbox_id_q, sbox_id_d;
  logic [DW-1:0]     sbox_in_q, sbox_in_d;
  logic [RAND_W-1:0] sbox_rand_q, sbox_rand_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]     rsp0_data_q, rsp0_data_d;
  logic [DW-1:0]     rsp1_data_q, rsp1_data_d;
  tag_t              tag_in, tag_out;
  logic              tag_busy;

  // Arbitration and issue stage; unused input stage is zeroed so no stale
  // shares or randomness reach the masked gadgets
  always_comb begin
    issue = RandValidxSI & (Req0ValidxSI | Req1ValidxSI) & ~RstxRI;
    if (Req0ValidxSI & Req1ValidxSI)
      grant_id = (last_q == REQ_KEY) ? REQ_STATE : REQ_KEY;
    else if (Req1ValidxSI)
      grant_id = REQ_KEY;
    else
      grant_id = REQ_STATE;

    last_d       = issue ? grant_id : last_q;
    sbox_valid_d = issue;
    sbox_id_d    = REQ_STATE;
    sbox_in_d    = '0;
    sbox_rand_d  = '0;
    if (issue) begin
      sbox_id_d   = grant_id;
      sbox_in_d   = (grant_id == REQ_KEY) ? Req1DataxDI : Req0DataxDI;
      sbox_rand_d = RandxDI;
    end
  end

  // Response routing from the tag at the S-box output
  always_comb begin
    rsp0_valid_d = tag_out.valid & (tag_out.id == REQ_STATE);
    rsp1_valid_d = tag_out.valid & (tag_out.id == REQ_KEY);
    rsp0_data_d  = rsp0_valid_d ? SboxOutxDI : '0;
    rsp1_data_d  = rsp1_valid_d ? SboxOutxDI : '0;
  end

  // Issue-stage, pointer and response registers
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      last_q       <= REQ_KEY;
      sbox_valid_q <= 1'b0;
      sbox_id_q    <= REQ_STATE;
      sbox_in_q    <= '0;
      sbox_rand_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_q       <= last_d;
      sbox_valid_q <= sbox_valid_d;
      sbox_id_q    <= sbox_id_d;
      sbox_in_q    <= sbox_in_d;
      sbox_rand_q  <= sbox_rand_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign tag_in.valid = sbox_valid_q;
  assign tag_in.id    = sbox_id_q;

  sbox_tag_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .ClkxCI      (ClkxCI),
    .RstxRI      (RstxRI),
    .TagInxDI    (tag_in),
    .TagOutxDO   (tag_out),
    .AnyValidxSO (tag_busy)
  );

  assign Req0ReadyxSO = issue & (grant_id == REQ_STATE);
  assign Req1ReadyxSO = issue & (grant_id == REQ_KEY);
  assign RandReadyxSO = issue;
  assign SboxValidxSO = sbox_valid_q;
  assign SboxInxDO    = sbox_in_q;
  assign SboxRandxDO  = sbox_rand_q;
  assign Rsp0ValidxSO = rsp0_valid_q;
  assign Rsp1ValidxSO = rsp1_valid_q;
  assign Rsp0DataxDO  = rsp0_data_q;
  assign Rsp1DataxDO  = rsp1_data_q;
  assign BusyxSO      = sbox_valid_q | tag_busy | rsp0_valid_q | rsp1_valid_q;

endmodule
